// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The state encoding is fixed so external tools can decode dbg_state directly.
package fetch_pkg;

    localparam int INST_W     = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with asynchronous active-low reset.
// When load and incr are both asserted, load (the redirect) wins.
module fetch_pc_reg #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              incr,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (incr) begin
            pc <= pc + PC_ONE;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one imem read per instruction, valid/ready hand-off
// to decode, and redirect handling that squashes wrong-path reads and holds.
//
// Handshake: decode takes the held instruction in a cycle where
// inst_valid & dec_ready & ~redirect_valid; a redirect always squashes the
// held instruction, so decode must ignore whatever it sees in that cycle.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_rvalid,
    input  logic [INST_W-1:0]   imem_rdata,
    output logic                inst_valid,
    input  logic                dec_ready,
    output logic [INST_W-1:0]   inst,
    output logic [OPCODE_W-1:0] inst_opcode,
    output logic [ADDR_W-1:0]   inst_pc,
    output logic [ADDR_W-1:0]   pc_plus1,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output fetch_state_t        dbg_state
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_t      state, state_nxt;
    logic              drop, drop_nxt;
    logic              valid_nxt;
    logic              capture;
    logic              pc_load;
    logic              pc_incr;
    logic [ADDR_W-1:0] pc;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock   (clock),
        .reset   (reset),
        .load    (pc_load),
        .load_pc (redirect_pc),
        .incr    (pc_incr),
        .pc      (pc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            drop       <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else begin
            state      <= state_nxt;
            drop       <= drop_nxt;
            inst_valid <= valid_nxt;
            if (capture) begin
                inst    <= imem_rdata;
                inst_pc <= pc;
            end
        end
    end

    // imem_rvalid is only meaningful in WAIT; elsewhere it is a stray and ignored.
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        valid_nxt = inst_valid;
        capture   = 1'b0;
        pc_load   = 1'b0;
        pc_incr   = 1'b0;
        imem_req  = 1'b0;
        case (state)
            FETCH: begin
                imem_req = reset & ~redirect_valid;
                if (redirect_valid) begin
                    pc_load = 1'b1;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (drop || redirect_valid) begin
                        drop_nxt  = 1'b0;
                        pc_load   = redirect_valid;
                        state_nxt = FETCH;
                    end else begin
                        capture   = 1'b1;
                        pc_incr   = 1'b1;
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_load  = 1'b1;
                    drop_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_load   = 1'b1;
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end else if (dec_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    assign imem_addr   = pc;
    assign inst_opcode = inst[OPCODE_MSB:OPCODE_LSB];
    assign pc_plus1    = inst_pc + PC_ONE;
    assign dbg_state   = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked
// against an instruction-stream model (sequential PCs restarted by redirects).
module tb_fetch_unit;
    import fetch_pkg::*;

    logic         clock;
    logic         reset;
    logic         imem_req;
    logic [11:0]  imem_addr;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    logic         inst_valid;
    logic         dec_ready;
    logic [31:0]  inst;
    logic [4:0]   inst_opcode;
    logic [11:0]  inst_pc;
    logic [11:0]  pc_plus1;
    logic         redirect_valid;
    logic [11:0]  redirect_pc;
    fetch_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:4095];
    logic [31:0] exp_q[$];
    int          lat;
    int          resp_cnt;
    logic [11:0] resp_addr;

    fetch_unit #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .dec_ready      (dec_ready),
        .inst           (inst),
        .inst_opcode    (inst_opcode),
        .inst_pc        (inst_pc),
        .pc_plus1       (pc_plus1),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dbg_state      (dbg_state)
    );

    // clock/reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic do_reset();
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; resp_cnt = 0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
    endtask

    // One clock cycle: drive inputs at negedge, let outputs settle, then
    // model the memory accepting a request that the next posedge will see.
    task automatic cycle(input logic redir, input logic [11:0] rpc, input logic rdy, input logic stray);
        @(negedge clock);
        redirect_valid = redir; redirect_pc = rpc; dec_ready = rdy;
        if (resp_cnt == 1) begin
            imem_rvalid = 1'b1; imem_rdata = mem[resp_addr]; resp_cnt = 0;
        end else begin
            if (resp_cnt > 1) resp_cnt--;
            imem_rvalid = stray; imem_rdata = stray ? 32'hDEAD_BEEF : 32'h0;
        end
        #1;
        if (imem_req && reset) begin resp_cnt = lat; resp_addr = imem_addr; end
    endtask

    task automatic test_reset();
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; resp_cnt = 0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", inst_valid); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", inst); end
        checks++; if (inst_pc !== 12'h0) begin errors++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc); end
        checks++; if (imem_addr !== 12'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
        checks++; if (dbg_state !== FETCH) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    endtask

    task automatic test_basic();
        mem[0] = 32'h2800_0005;
        do_reset(); lat = 1;
        cycle(1'b0, 12'h0, 1'b1, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin errors++; $display("FAIL basic_req0 got %0b/%h exp 1/000", imem_req, imem_addr); end
        cycle(1'b0, 12'h0, 1'b1, 1'b0);
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL basic_wait got req %0b valid %0b exp 0/0", imem_req, inst_valid); end
        cycle(1'b0, 12'h0, 1'b1, 1'b0);
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", inst_valid); end
        checks++; if (inst_opcode !== 5'b00101) begin errors++; $display("FAIL basic_opcode got %b exp 00101", inst_opcode); end
        checks++; if (inst !== 32'h2800_0005 || inst_pc !== 12'h000) begin errors++; $display("FAIL basic_inst got %h@%h exp 28000005@000", inst, inst_pc); end
        checks++; if (pc_plus1 !== 12'h001) begin errors++; $display("FAIL basic_pc_plus1 got %h exp 001", pc_plus1); end
        cycle(1'b0, 12'h0, 1'b1, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h001 || inst_valid !== 1'b0) begin errors++; $display("FAIL basic_req1 got %0b/%h valid %0b exp 1/001 valid 0", imem_req, imem_addr, inst_valid); end
    endtask

    task automatic test_stall();
        int reqs;
        do_reset(); lat = 3; reqs = 0;
        cycle(1'b0, 12'h0, 1'b0, 1'b0);
        repeat (3) begin cycle(1'b0, 12'h0, 1'b0, 1'b0); if (imem_req) reqs++; end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 12'h0, 1'b0, 1'b0);
            if (imem_req) reqs++;
            checks++; if (inst_valid !== 1'b1 || inst !== mem[0] || inst_pc !== 12'h000) begin errors++; $display("FAIL stall_hold%0d got %0b %h@%h exp 1 %h@000", i, inst_valid, inst, inst_pc, mem[0]); end
        end
        cycle(1'b0, 12'h0, 1'b1, 1'b0);
        if (imem_req) reqs++;
        checks++; if (reqs !== 0) begin errors++; $display("FAIL stall_extra_req got %0d exp 0", reqs); end
        cycle(1'b0, 12'h0, 1'b1, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h001) begin errors++; $display("FAIL stall_next_req got %0b/%h exp 1/001", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        int valids;
        do_reset(); lat = 3; valids = 0;
        cycle(1'b1, 12'h007, 1'b1, 1'b0);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_req_on_redirect got %0b exp 0", imem_req); end
        cycle(1'b0, 12'h0, 1'b1, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h007) begin errors++; $display("FAIL rdw_req7 got %0b/%h exp 1/007", imem_req, imem_addr); end
        cycle(1'b1, 12'h040, 1'b1, 1'b0); if (inst_valid) valids++;
        cycle(1'b0, 12'h0, 1'b1, 1'b0);   if (inst_valid) valids++;
        cycle(1'b0, 12'h0, 1'b1, 1'b0);   if (inst_valid) valids++;
        cycle(1'b0, 12'h0, 1'b1, 1'b0);   if (inst_valid) valids++;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h040) begin errors++; $display("FAIL rdw_req40 got %0b/%h exp 1/040", imem_req, imem_addr); end
        checks++; if (valids !== 0) begin errors++; $display("FAIL rdw_squashed_valid got %0d exp 0", valids); end
    endtask

    task automatic test_redirect_hold();
        do_reset(); lat = 1;
        cycle(1'b0, 12'h0, 1'b0, 1'b0);
        cycle(1'b0, 12'h0, 1'b0, 1'b0);
        cycle(1'b1, 12'h100, 1'b1, 1'b0);
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rdh_valid got %0b exp 1", inst_valid); end
        cycle(1'b0, 12'h0, 1'b0, 1'b0);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdh_valid_drop got %0b exp 0", inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h100) begin errors++; $display("FAIL rdh_req got %0b/%h exp 1/100", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        do_reset(); lat = 1;
        cycle(1'b1, 12'hFFF, 1'b1, 1'b0);
        cycle(1'b0, 12'h0, 1'b1, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'hFFF) begin errors++; $display("FAIL wrap_reqfff got %0b/%h exp 1/fff", imem_req, imem_addr); end
        cycle(1'b0, 12'h0, 1'b1, 1'b0);
        cycle(1'b0, 12'h0, 1'b1, 1'b0);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 12'hFFF || inst !== mem[12'hFFF]) begin errors++; $display("FAIL wrap_inst got %0b %h@%h exp 1 %h@fff", inst_valid, inst, inst_pc, mem[12'hFFF]); end
        checks++; if (pc_plus1 !== 12'h000) begin errors++; $display("FAIL wrap_pc_plus1 got %h exp 000", pc_plus1); end
        cycle(1'b0, 12'h0, 1'b1, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin errors++; $display("FAIL wrap_req0 got %0b/%h exp 1/000", imem_req, imem_addr); end
    endtask

    task automatic test_stray_rvalid();
        do_reset(); lat = 2;
        cycle(1'b0, 12'h0, 1'b0, 1'b1);
        cycle(1'b0, 12'h0, 1'b0, 1'b0);
        checks++; if (dbg_state !== WAIT || inst_valid !== 1'b0) begin errors++; $display("FAIL stray_fetch got state %0d valid %0b exp 1/0", dbg_state, inst_valid); end
        cycle(1'b0, 12'h0, 1'b0, 1'b0);
        cycle(1'b0, 12'h0, 1'b0, 1'b1);
        cycle(1'b0, 12'h0, 1'b0, 1'b0);
        checks++; if (dbg_state !== HOLD || inst_valid !== 1'b1 || inst !== mem[0]) begin errors++; $display("FAIL stray_hold got state %0d valid %0b inst %h exp 2/1/%h", dbg_state, inst_valid, inst, mem[0]); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset(); lat = 1;
        cycle(1'b0, 12'h0, 1'b1, 1'b0);
        cycle(1'b0, 12'h0, 1'b1, 1'b0);
        cycle(1'b0, 12'h0, 1'b1, 1'b0);
        lat = 4;
        cycle(1'b0, 12'h0, 1'b0, 1'b0);
        cycle(1'b0, 12'h0, 1'b0, 1'b0);
        checks++; if (dbg_state !== WAIT || inst !== 32'h2800_0005) begin errors++; $display("FAIL rmw_setup got state %0d inst %h exp 1/28000005", dbg_state, inst); end
        #1 reset = 1'b0; resp_cnt = 0;
        #1;
        checks++; if (dbg_state !== FETCH || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 12'h0 || imem_req !== 1'b0 || imem_addr !== 12'h0) begin
            errors++; $display("FAIL rmw_async got state %0d valid %0b inst %h pc %h req %0b addr %h exp all zero", dbg_state, inst_valid, inst, inst_pc, imem_req, imem_addr);
        end
        cycle(1'b0, 12'h0, 1'b0, 1'b1);
        checks++; if (imem_req !== 1'b0 || dbg_state !== FETCH) begin errors++; $display("FAIL rmw_rvalid_in_reset got req %0b state %0d exp 0/0", imem_req, dbg_state); end
        @(posedge clock);
        #2 reset = 1'b1; lat = 1;
        cycle(1'b0, 12'h0, 1'b0, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin errors++; $display("FAIL rmw_first_req got %0b/%h exp 1/000", imem_req, imem_addr); end
    endtask

    // Random traffic: accepted instructions must follow the PC stream that
    // restarts at every redirect target, carrying mem[pc] for each PC.
    task automatic test_random();
        logic [11:0] model_next;
        logic        redir, rdy, stall_prev;
        logic [11:0] rpc, prev_pc;
        logic [31:0] prev_inst, exp_w;
        int          accepts;
        do_reset();
        model_next = 12'h000; exp_q.delete(); accepts = 0; stall_prev = 1'b0;
        prev_pc = '0; prev_inst = '0;
        for (int n = 0; n < 800; n++) begin
            redir = ($urandom_range(0, 9) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? 12'hFFE : 12'($urandom);
            rdy   = ($urandom_range(0, 9) < 7);
            lat   = $urandom_range(1, 4);
            cycle(redir, rpc, rdy, 1'b0);
            if (stall_prev) begin
                checks++; if (inst_valid !== 1'b1 || inst !== prev_inst || inst_pc !== prev_pc) begin errors++; $display("FAIL rnd_stable got %0b %h@%h exp 1 %h@%h", inst_valid, inst, inst_pc, prev_inst, prev_pc); end
            end
            if (imem_req) begin
                checks++; if (imem_addr !== model_next) begin errors++; $display("FAIL rnd_req_addr got %h exp %h", imem_addr, model_next); end
                exp_q.push_back(mem[model_next]);
            end
            if (inst_valid && rdy && !redir) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_unexpected_inst got %h@%h exp none", inst, inst_pc);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (inst !== exp_w || inst_pc !== model_next || inst_opcode !== exp_w[31:27] || pc_plus1 !== model_next + 12'h001) begin
                        errors++; $display("FAIL rnd_accept got %h@%h op %b p1 %h exp %h@%h", inst, inst_pc, inst_opcode, pc_plus1, exp_w, model_next);
                    end
                end
                model_next = model_next + 12'h001;
                accepts++;
            end
            if (redir) begin
                model_next = rpc;
                exp_q.delete();
            end
            stall_prev = inst_valid && !rdy && !redir;
            prev_inst  = inst;
            prev_pc    = inst_pc;
        end
        checks++; if (accepts < 20) begin errors++; $display("FAIL rnd_progress got %0d exp >=20", accepts); end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = $urandom;
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_stray_rvalid();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the opcode decoder/controller. It holds the PC and issues one word read per instruction to instruction memory, which may have variable latency. It presents the fetched instruction, its PC and its opcode field to decode with a valid/ready handshake. It also accepts branch/jump redirects from execute, squashing any wrong-path work.

Parameters:
ADDR_W, 12, PC / instruction-memory word-address width (4096 words)
RESET_PC, 0, PC value loaded on reset

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
imem_req  output  1  one-cycle read request pulse
imem_addr  output  ADDR_W  word address for imem_req; equals pc
imem_rvalid  input  1  read data valid; at most one per request, arrives ≥1 cycle after the request
imem_rdata  input  32  instruction word
inst_valid  output  1  inst/inst_pc/inst_opcode are valid for decode
dec_ready  input  1  decode accepts this cycle
inst  output  32  held instruction
inst_opcode  output  5  inst[31:27], fed to the controller
inst_pc  output  ADDR_W  PC of the held instruction
pc_plus1  output  ADDR_W  inst_pc+1 mod 2^ADDR_W (jal link, branch base)
redirect_valid  input  1  taken branch/jump from execute
redirect_pc  input  ADDR_W  target PC

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC, state=FETCH, drop=0, inst_valid=0, inst=0, inst_pc=0. imem_req is held at 0 while reset=0. Reset mid-WAIT abandons the outstanding read. Any imem_rvalid that arrives later while the unit is in FETCH is ignored.
- States: FETCH, WAIT, HOLD.
- FETCH:
  - imem_req = ~redirect_valid, combinational; imem_addr = pc.
  - If redirect_valid: pc<=redirect_pc, stay in FETCH, no request issued.
  - Else go to WAIT.
- WAIT: one read is outstanding; imem_req=0.
  - redirect_valid without imem_rvalid: pc<=redirect_pc, drop<=1.
  - imem_rvalid with (drop | redirect_valid): discard the data, drop<=0, go to FETCH. If redirect_valid, also pc<=redirect_pc.
  - imem_rvalid otherwise: inst<=imem_rdata, inst_pc<=pc, pc<=pc+1 (wraps 2^ADDR_W-1 -> 0), inst_valid<=1, go to HOLD.
- HOLD: inst_valid=1; outputs stay stable until the transfer completes.
  - A transfer is inst_valid & dec_ready & ~redirect_valid. On transfer: inst_valid<=0, go to FETCH.
  - redirect_valid has priority over dec_ready. It squashes the held instruction: inst_valid<=0, pc<=redirect_pc, go to FETCH. Decode must not act on an instruction seen in the same cycle as redirect_valid.
- imem_rvalid in FETCH or HOLD is a protocol error. It is ignored and must not change state.
- Best-case throughput is one instruction per 3 cycles (FETCH, WAIT with latency 1, HOLD accepted at once).
- inst_opcode and pc_plus1 are combinational from the registers.

Decomposition:
- fetch_pkg:
  - state encoding (FETCH=2'd0, WAIT=2'd1, HOLD=2'd2)
  - OPCODE_MSB=31, OPCODE_LSB=27
  - INST_W=32
- One sub-module is natural: fetch_pc_reg, the PC register with async active-low reset to RESET_PC. It has load (redirect) and increment inputs, with load taking priority.

Test Plan:
1. Reset release, imem latency 1, rdata=0x2800_0005, dec_ready=1 -> req at addr 0 in cycle 1; inst_valid in cycle 3 with inst_opcode=5'b00101 and inst_pc=0; next req at addr 1 in cycle 4.
2. Latency 3, dec_ready held 0 for 4 cycles -> one req only; inst/inst_pc stay stable through the stall; after dec_ready=1, next req is at pc+1.
3. redirect_valid (redirect_pc=0x040) in the cycle after the req to addr 7; rvalid arrives 2 cycles later -> data discarded; next req at 0x040; inst_valid never asserted for addr 7.
4. In HOLD, redirect_valid and dec_ready both high with redirect_pc=0x100 -> inst_valid drops next cycle, no transfer counted, next req at 0x100.
5. pc=0xFFF fetched and accepted -> pc_plus1=0x000; next req at addr 0x000.
6. reset=0 mid-WAIT, then an rvalid pulse while reset=0 -> all outputs at reset values immediately (asynchronously); after release, first req at RESET_PC.
